smm_driver: RTL and testbench

Initiator-side sequencer for the 2x2 Strassen multiply core. Accepts a serial stream of signed matrix elements, packs them into the core's A/B buses, and issues a single-cycle load with the correct mode select. It tracks the core's fixed pipeline latency, captures the packed result, and re-serialises it onto a valid/ready output stream. Exactly one job is in flight at a time; the driver sits between the SNN datapath's element streams and one multiply core instance.

---
 rtl/smm_driver_if.sv | 29 ++
 rtl/smm_driver.sv | 124 ++++++++++++
 tb/tb_smm_driver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/smm_driver_if.sv
// rtl/smm_driver_if.sv - element streams and core bus between smm_driver and its neighbours
interface smm_driver_if #(
  parameter int DATAWIDTH = 32,
  parameter int BUSWIDTH  = 4*DATAWIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_last;
  logic [BUSWIDTH-1:0]  smm_A;
  logic [BUSWIDTH-1:0]  smm_B;
  logic [BUSWIDTH-1:0]  smm_C;
  logic                 smm_load;
  logic                 smm_sel;

  modport master (
    input  in_valid, in_data, in_mode, out_ready, smm_C,
    output in_ready, out_valid, out_data, out_last, smm_A, smm_B, smm_load, smm_sel
  );

  modport slave (
    output in_valid, in_data, in_mode, out_ready, smm_C,
    input  in_ready, out_valid, out_data, out_last, smm_A, smm_B, smm_load, smm_sel
  );
endinterface

// File: rtl/smm_driver.sv
// rtl/smm_driver.sv - serial-to-packed job sequencer for the 2x2 Strassen multiply core
// Optional macro SMM_DRV_CNT_EN adds the jobs_done completed-job counter port.
module smm_driver #(
  parameter int DATAWIDTH = 32,
  parameter int BUSWIDTH  = 4*DATAWIDTH,
  parameter int CORE_LAT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  smm_driver_if.master bus,
  output logic         busy
`ifdef SMM_DRV_CNT_EN
  ,
  output logic [15:0]  jobs_done
`endif
);
  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, DRAIN} state_t;
  localparam logic [7:0] LAT = 8'(CORE_LAT);

  state_t              state, state_nxt;
  logic [2:0]          idx;
  logic [1:0]          oidx;
  logic [7:0]          cnt;
  logic                mode;
  logic [BUSWIDTH-1:0] res;
  logic                in_fire, out_fire, last_in, last_out;
  logic [1:0]          a_blk, b_blk, o_blk;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign last_in  = (idx == (mode ? 3'd5 : 3'd7));
  assign last_out = (oidx == (mode ? 2'd1 : 2'd3));
  assign a_blk    = idx[1:0];
  // Matrix x vector places b0/b1 in column 0 of B (blocks 0 and 2); y0/y1 come back there too.
  assign b_blk    = mode ? {idx[0], 1'b0} : idx[1:0];
  assign o_blk    = mode ? {oidx[0], 1'b0} : oidx;

  assign bus.smm_sel = mode;
  assign busy        = (state != COLLECT) || (idx != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.smm_load  = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (in_fire && last_in) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.smm_load = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (cnt == LAT) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_out;
        if (out_fire && last_out) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid && o_blk == 2'(k)) bus.out_data = res[k*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      oidx      <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      res       <= '0;
      bus.smm_A <= '0;
      bus.smm_B <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            idx <= last_in ? 3'd0 : idx + 3'd1;
            // A new job clears B so unused matrix x vector blocks read as zero.
            if (idx == 3'd0) begin
              mode      <= bus.in_mode;
              bus.smm_B <= '0;
            end
            for (int k = 0; k < 4; k++) begin
              if (!idx[2] && a_blk == 2'(k)) bus.smm_A[k*DATAWIDTH +: DATAWIDTH] <= bus.in_data;
              if (idx[2] && b_blk == 2'(k))  bus.smm_B[k*DATAWIDTH +: DATAWIDTH] <= bus.in_data;
            end
          end
        end
        ISSUE: cnt <= 8'd1;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == LAT) res <= bus.smm_C;
        end
        DRAIN: begin
          if (out_fire) oidx <= last_out ? 2'd0 : oidx + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SMM_DRV_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           jobs_done <= '0;
    else if (out_fire && bus.out_last) jobs_done <= jobs_done + 16'd1;
  end
`endif
endmodule

// File: tb/tb_smm_driver.sv
// tb/tb_smm_driver.sv - directed self-checking bench for smm_driver with a fixed-latency core stand-in
module tb_smm_driver;
  localparam int DW       = 32;
  localparam int CORE_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef SMM_DRV_CNT_EN
  logic [15:0] jobs_done;
`endif

  smm_driver_if #(.DATAWIDTH(DW), .BUSWIDTH(4*DW)) bus ();

  smm_driver #(.DATAWIDTH(DW), .BUSWIDTH(4*DW), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
`ifdef SMM_DRV_CNT_EN
    ,
    .jobs_done(jobs_done)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core stand-in: plain 2x2 product, valid on smm_C only in cycle CORE_LAT after the load.
  function automatic logic [127:0] mm(input logic [127:0] a, input logic [127:0] b);
    logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [31:0] c0, c1, c2, c3;
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    c0 = a0*b0 + a1*b2;
    c1 = a0*b1 + a1*b3;
    c2 = a2*b0 + a3*b2;
    c3 = a2*b1 + a3*b3;
    return {c3, c2, c1, c0};
  endfunction

  logic [127:0] core_res = '0;
  int           lat_cnt  = 0;
  always @(posedge clk) begin
    if (bus.smm_load) begin
      core_res <= mm(bus.smm_A, bus.smm_B);
      lat_cnt  <= 1;
    end else if (lat_cnt != 0 && lat_cnt <= CORE_LAT) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end
  assign bus.smm_C = (lat_cnt == CORE_LAT) ? core_res : {4{32'hDEADBEEF}};

  int   cyc = 0, acc_cnt = 0, load_cnt = 0;
  int   last_in_cyc = 0, load_cyc = 0, first_ov_cyc = 0;
  logic ov_prev = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ov_prev <= bus.out_valid;
    if (bus.in_valid && bus.in_ready) begin
      acc_cnt     <= acc_cnt + 1;
      last_in_cyc <= cyc;
    end
    if (bus.smm_load) begin
      load_cnt <= load_cnt + 1;
      load_cyc <= cyc;
    end
    if (bus.out_valid && !ov_prev) first_ov_cyc <= cyc;
  end

  logic [31:0] e1 [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
  logic [31:0] r1 [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
  logic [31:0] e2 [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd0, 32'd0};
  logic [31:0] r2 [4] = '{32'd19, 32'd43, 32'd0, 32'd0};
  logic [31:0] e3 [8] = '{32'hFFFFFFFF, 32'd2, 32'd3, 32'hFFFFFFFC, 32'd1, 32'd0, 32'd0, 32'd1};
  logic [31:0] r3 [4] = '{32'hFFFFFFFF, 32'd2, 32'd3, 32'hFFFFFFFC};
  localparam logic [127:0] A1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] B1 = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] B2 = 128'h00000000_00000007_00000000_00000005;
  localparam logic [127:0] A3 = 128'hFFFFFFFC_00000003_00000002_FFFFFFFF;
  localparam logic [127:0] B3 = 128'h00000001_00000000_00000000_00000001;

  task automatic push(input logic [31:0] d, input logic m);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("push_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load"}, bus.smm_load, 0);
    check({tag, "_sel"}, bus.smm_sel, 0);
    check({tag, "_smm_A"}, bus.smm_A, 0);
    check({tag, "_smm_B"}, bus.smm_B, 0);
`ifdef SMM_DRV_CNT_EN
    check({tag, "_jobs_done"}, jobs_done, 0);
`endif
  endtask

  task automatic run_job(input string tag, input logic m, input logic [31:0] e [8], input int n,
                         input logic [127:0] exp_a, input logic [127:0] exp_b,
                         input logic [31:0] r [4], input int nr, input bit stall);
    int acc0, ld0, w;
    acc0 = acc_cnt;
    ld0  = load_cnt;
    // in_mode toggles after idx 0 to show it is ignored there.
    for (int i = 0; i < n; i++) push(e[i], (i == 0) ? m : !m);
    check({tag, "_issue_load"}, bus.smm_load, 1);
    check({tag, "_issue_in_ready"}, bus.in_ready, 0);
    check({tag, "_issue_sel"}, bus.smm_sel, m);
    check({tag, "_smm_A"}, bus.smm_A, exp_a);
    check({tag, "_smm_B"}, bus.smm_B, exp_b);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5A5A5A5A;
    bus.in_mode   = 1'b1;
    bus.out_ready = !stall;
    for (int j = 0; j < nr; j++) begin
      w = 0;
      while (!bus.out_valid && w < 4*CORE_LAT + 10) begin
        @(negedge clk);
        w++;
      end
      check({tag, "_out_valid"}, bus.out_valid, 1);
      if (j == 0) check({tag, "_A_held"}, bus.smm_A, exp_a);
      check($sformatf("%s_out_data%0d", tag, j), bus.out_data, r[j]);
      check($sformatf("%s_out_last%0d", tag, j), bus.out_last, (j == nr - 1));
      check($sformatf("%s_drain_sel%0d", tag, j), bus.smm_sel, m);
      if (stall) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check($sformatf("%s_hold%0d_%0d", tag, j, s),
                {bus.out_valid, bus.out_last, bus.out_data, bus.in_ready, busy},
                {1'b1, (j == nr - 1), r[j], 1'b0, 1'b1});
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (stall) bus.out_ready = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_in_ready"}, bus.in_ready, 1);
    check({tag, "_end_out_valid"}, bus.out_valid, 0);
    check({tag, "_accepted"}, acc_cnt - acc0, n);
    check({tag, "_loads"}, load_cnt - ld0, 1);
    check({tag, "_lat_load"}, load_cyc - last_in_cyc, 1);
    check({tag, "_lat_out"}, first_ov_cyc - last_in_cyc, CORE_LAT + 2);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    run_job("j1_mm", 1'b0, e1, 8, A1, B1, r1, 4, 1'b0);
    run_job("j2_mv", 1'b1, e2, 6, A1, B2, r2, 2, 1'b0);
    run_job("j3_neg_bp", 1'b0, e3, 8, A3, B3, r3, 4, 1'b1);
`ifdef SMM_DRV_CNT_EN
    check("jobs_done_3", jobs_done, 3);
`endif

    for (int i = 0; i < 8; i++) push(e1[i], 1'b0);
    check("abort_issue_load", bus.smm_load, 1);
    @(negedge clk);
    check("abort_wait_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_wait");
    rst = 1'b0;
    @(negedge clk);
    run_job("j4_after_rst", 1'b0, e1, 8, A1, B1, r1, 4, 1'b0);
`ifdef SMM_DRV_CNT_EN
    check("jobs_done_after_rst", jobs_done, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
